uart_reg_responder: RTL and testbench

Byte-level register-access responder sitting between `uart_rx` and `uart_tx`, sharing their tick domain but not the tick itself. It consumes received bytes, decodes one- or two-byte read/write commands against an internal 8-bit register file, and returns exactly one response byte per command through the `uart_tx` enable/busy/done handshake. It is the device end of the host link: the host sends commands, and this block answers them.

---
 rtl/uart_reg_responder.sv | 149 ++++++++++++++
 tb/tb_uart_reg_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_responder.sv
// Byte-level register responder between uart_rx and uart_tx: decodes read/write commands, answers one byte each.
// Optional WAIT_DATA timeout compiled in with `define UART_RESP_TIMEOUT_EN.
module uart_reg_responder #(
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 20_000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [7:0]            rx_data_in,
    input  logic                  rx_done_in,
    output logic [7:0]            tx_data_out,
    output logic                  tx_enable_out,
    input  logic                  tx_busy_in,
    input  logic                  tx_done_in,
    output logic [NUM_REGS*8-1:0] regs_out,
    output logic                  drop_out
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        SEND      = 2'd2,
        WAIT_TX   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  regs [NUM_REGS];
    logic [6:0]  addr_q;
    logic [6:0]  addr_next;
    logic [7:0]  tx_data_next;
    logic        wr_en;
    logic        drop_next;
    logic        timeout;
    logic [7:0]  rd_byte;

    // Full 7-bit compare; out-of-range addresses never alias into the file.
    function automatic logic in_range(input logic [6:0] a);
        return {1'b0, a} < 8'(NUM_REGS);
    endfunction

    assign rd_byte = regs[IDX_W'(rx_data_in[6:0])];

`ifdef UART_RESP_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TO_W-1:0] to_cnt;

    // Held at zero outside WAIT_DATA so it starts cleared on every entry.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            to_cnt <= '0;
        end else if (state != WAIT_DATA) begin
            to_cnt <= '0;
        end else if (!timeout) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout = (state == WAIT_DATA) && (to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // Start strobe is a direct function of SEND and busy so it can never overlap busy.
    assign tx_enable_out = (state == SEND) && !tx_busy_in;

    always_comb begin
        state_next   = state;
        addr_next    = addr_q;
        tx_data_next = tx_data_out;
        wr_en        = 1'b0;
        drop_next    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_done_in) begin
                    if (rx_data_in[7]) begin
                        addr_next  = rx_data_in[6:0];
                        state_next = WAIT_DATA;
                    end else begin
                        tx_data_next = in_range(rx_data_in[6:0]) ? rd_byte : NAK_BYTE;
                        state_next   = SEND;
                    end
                end
            end
            WAIT_DATA: begin
                // A data byte arriving on the timeout cycle still wins.
                if (rx_done_in) begin
                    wr_en        = in_range(addr_q);
                    tx_data_next = in_range(addr_q) ? ACK_BYTE : NAK_BYTE;
                    state_next   = SEND;
                end else if (timeout) begin
                    drop_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            SEND: begin
                drop_next = rx_done_in;
                if (!tx_busy_in) begin
                    state_next = WAIT_TX;
                end
            end
            WAIT_TX: begin
                drop_next = rx_done_in;
                if (tx_done_in) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            addr_q      <= '0;
            tx_data_out <= '0;
            drop_out    <= 1'b0;
        end else begin
            state       <= state_next;
            addr_q      <= addr_next;
            tx_data_out <= tx_data_next;
            drop_out    <= drop_next;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                regs[k] <= '0;
            end
        end else if (wr_en) begin
            regs[IDX_W'(addr_q)] <= rx_data_in;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            regs_out[k*8 +: 8] = regs[k];
        end
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench for uart_reg_responder: directed test-plan cases plus randomized commands vs. a byte-array model.
module tb_uart_reg_responder;

    localparam int unsigned NUM_REGS       = 16;
    localparam int unsigned TIMEOUT_CYCLES = 20_000;
    localparam logic [7:0]  ACK            = 8'h06;
    localparam logic [7:0]  NAK            = 8'h15;
    localparam int unsigned RW             = NUM_REGS * 8;

    logic          clk;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic [7:0]    tx_data;
    logic          tx_enable;
    logic          tx_busy;
    logic          tx_done;
    logic [RW-1:0] regs_flat;
    logic          drop;

    logic          stub_busy;
    logic          hold_busy;
    logic          tx_done_r;
    int            tx_cnt;

    logic [7:0]    m_regs [NUM_REGS];
    logic [7:0]    exp_q [$];
    int            drop_exp;
    int            drop_seen;
    int            n_tests;
    int            n_fail;

    uart_reg_responder #(
        .NUM_REGS      (NUM_REGS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .ACK_BYTE      (ACK),
        .NAK_BYTE      (NAK)
    ) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .rx_data_in   (rx_data),
        .rx_done_in   (rx_done),
        .tx_data_out  (tx_data),
        .tx_enable_out(tx_enable),
        .tx_busy_in   (tx_busy),
        .tx_done_in   (tx_done),
        .regs_out     (regs_flat),
        .drop_out     (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_busy = stub_busy | hold_busy;
    assign tx_done = tx_done_r;

    // Minimal uart_tx stand-in: busy for a few cycles after a start, then a done strobe.
    always @(posedge clk) begin
        tx_done_r <= 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) begin
                stub_busy <= 1'b0;
                tx_done_r <= 1'b1;
            end
        end else if (tx_enable) begin
            stub_busy <= 1'b1;
            tx_cnt    <= int'($urandom_range(2, 6));
        end
    end

    function automatic logic [RW-1:0] model_flat();
        logic [RW-1:0] f;
        for (int k = 0; k < int'(NUM_REGS); k++) f[k*8 +: 8] = m_regs[k];
        return f;
    endfunction

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every start strobe is one response, checked against the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (drop) drop_seen++;
            if (tx_enable) begin
                check("enable_while_busy", RW'(tx_busy), RW'(0));
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_response actual=%h expected=none", tx_data);
                end else begin
                    check("response_byte", RW'(tx_data), RW'(exp_q.pop_front()));
                    check("regs_at_response", regs_flat, model_flat());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        while ((stub_busy || tx_done_r) && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        if (k >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_wait_expired actual=%0d expected=<300", k);
        end
        check("drop_count", RW'(drop_seen), RW'(drop_exp));
    endtask

    task automatic issue_read(input logic [6:0] a, input bit inject);
        exp_q.push_back((int'(a) < int'(NUM_REGS)) ? m_regs[a] : NAK);
        send_byte({1'b0, a});
        @(negedge clk);
        check("read_latency", RW'(tx_enable), RW'(1));
        if (inject) begin
            send_byte(8'h01);
            drop_exp++;
        end
        wait_idle();
    endtask

    task automatic issue_write(input logic [6:0] a, input logic [7:0] d, input int gap);
        send_byte({1'b1, a});
        repeat (gap) @(posedge clk);
        if (int'(a) < int'(NUM_REGS)) begin
            m_regs[a] = d;
            exp_q.push_back(ACK);
        end else begin
            exp_q.push_back(NAK);
        end
        send_byte(d);
        @(negedge clk);
        check("write_latency", RW'(tx_enable), RW'(1));
        check("write_regs", regs_flat, model_flat());
        wait_idle();
    endtask

    initial begin
        int bad;
        n_tests   = 0;
        n_fail    = 0;
        drop_exp  = 0;
        drop_seen = 0;
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_done   = 1'b0;
        hold_busy = 1'b0;
        stub_busy = 1'b0;
        tx_done_r = 1'b0;
        tx_cnt    = 0;
        for (int k = 0; k < int'(NUM_REGS); k++) m_regs[k] = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_regs", regs_flat, RW'(0));
        check("reset_tx_data", RW'(tx_data), RW'(0));
        check("reset_enable", RW'(tx_enable), RW'(0));
        check("reset_drop", RW'(drop), RW'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Write then read back, out-of-range read and write.
        issue_write(7'd5, 8'h3C, 0);
        check("reg5_field", RW'(regs_flat[47:40]), RW'(8'h3C));
        issue_read(7'd5, 1'b0);
        issue_read(7'h10, 1'b0);
        issue_write(7'h10, 8'hFF, 1);
        issue_read(7'h7F, 1'b0);

        // Start strobe held off while the transmitter is busy.
        hold_busy = 1'b1;
        exp_q.push_back(m_regs[5]);
        send_byte(8'h05);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_enable) bad++;
        end
        check("busy_hold_enable_low", RW'(bad), RW'(0));
        @(posedge clk);
        #1 hold_busy = 1'b0;
        @(negedge clk);
        check("enable_after_busy", RW'(tx_enable), RW'(1));
        wait_idle();

        // Byte arriving during WAIT_TX is dropped, no second response.
        issue_read(7'd5, 1'b1);

`ifdef UART_RESP_TIMEOUT_EN
        send_byte(8'h82);
        repeat (TIMEOUT_CYCLES + 5) @(negedge clk);
        drop_exp++;
        wait_idle();
        issue_read(7'd2, 1'b0);
`else
        send_byte(8'h82);
        repeat (30_000) @(negedge clk);
        m_regs[2] = 8'h77;
        exp_q.push_back(ACK);
        send_byte(8'h77);
        wait_idle();
        check("late_write_reg2", RW'(regs_flat[23:16]), RW'(8'h77));
        issue_read(7'd2, 1'b0);
`endif

        // Randomized command stream.
        for (int i = 0; i < 150; i++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, NUM_REGS + 3));
            if ($urandom_range(0, 1) == 0)
                issue_write(a, 8'($urandom), int'($urandom_range(0, 4)));
            else
                issue_read(a, $urandom_range(0, 4) == 0);
        end

        // Reset in the middle of a write command.
        issue_write(7'd5, 8'h3C, 0);
        send_byte(8'h82);
        #3 rst_n = 1'b0;
        #1;
        check("midcmd_reset_regs", regs_flat, RW'(0));
        check("midcmd_reset_tx_data", RW'(tx_data), RW'(0));
        check("midcmd_reset_enable", RW'(tx_enable), RW'(0));
        check("midcmd_reset_drop", RW'(drop), RW'(0));
        for (int k = 0; k < int'(NUM_REGS); k++) m_regs[k] = 8'h00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue_read(7'd5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
